// File: rtl/button_debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package button_debounce_pkg;

    localparam int SYNC_STAGES = 2;

    // Width needed for a counter that must hold values 0..n.
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/button_sync.sv
// Parameterised-depth flip-flop synchroniser with synchronous reset to 0.
module button_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Shift the raw level through the synchroniser chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: synchronise, then require N stable cycles before updating.
// Optional BUTTON_DEBOUNCE_EDGE_EN adds one-cycle press/release strobes.
module button_debounce
    import button_debounce_pkg::*;
#(
    parameter int CLK_FREQ        = 95_000,
    parameter int DEBOUNCE_PER_MS = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic button_in,
`ifdef BUTTON_DEBOUNCE_EDGE_EN
    output logic button_press,
    output logic button_release,
`endif
    output logic button_valid
);

    localparam int N  = CLK_FREQ * DEBOUNCE_PER_MS;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(N - 1);

    logic          sync_s;
    logic          commit_s;
    logic [CW-1:0] cnt_r;
    logic          valid_r;

    button_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (button_in),
        .q   (sync_s)
    );

    // The Nth consecutive differing cycle commits the new level.
    assign commit_s = (sync_s != valid_r) && (cnt_r == CNT_MAX);

    // Stability counter and debounced level; any agreement restarts the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r   <= CNT_ZERO;
            valid_r <= 1'b0;
        end else if (commit_s) begin
            cnt_r   <= CNT_ZERO;
            valid_r <= sync_s;
        end else if (sync_s == valid_r) begin
            cnt_r   <= CNT_ZERO;
            valid_r <= valid_r;
        end else begin
            cnt_r   <= cnt_r + CNT_ONE;
            valid_r <= valid_r;
        end
    end

    assign button_valid = valid_r;

`ifdef BUTTON_DEBOUNCE_EDGE_EN
    logic press_r;
    logic release_r;

    // Strobes share the commit edge so they coincide with the level change.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_r   <= 1'b0;
            release_r <= 1'b0;
        end else begin
            press_r   <= commit_s & sync_s;
            release_r <= commit_s & ~sync_s;
        end
    end

    assign button_press   = press_r;
    assign button_release = release_r;
`endif

endmodule

// File: tb/tb_button_debounce.sv
// Directed self-checking bench for button_debounce, scaled to N = 20 cycles.
module tb_button_debounce;

    localparam int N = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic button_in = 1'b0;
    logic button_valid;
`ifdef BUTTON_DEBOUNCE_EDGE_EN
    logic button_press;
    logic button_release;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;

    button_debounce #(
        .CLK_FREQ        (1),
        .DEBOUNCE_PER_MS (20)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .button_in      (button_in),
`ifdef BUTTON_DEBOUNCE_EDGE_EN
        .button_press   (button_press),
        .button_release (button_release),
`endif
        .button_valid   (button_valid)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s observed=%0d expected=%0d at t=%0t", tag, obs, exp, $time);
    endtask

    // Drive a level for cyc cycles; the output must hold exp_v with no strobes.
    task automatic run(input string tag, input logic lvl, input int cyc, input logic exp_v);
        button_in = lvl;
        for (int i = 0; i < cyc; i++) begin
            step();
            check(tag, {31'd0, button_valid}, {31'd0, exp_v});
`ifdef BUTTON_DEBOUNCE_EDGE_EN
            check({tag, "_press"}, {31'd0, button_press}, 32'd0);
            check({tag, "_release"}, {31'd0, button_release}, 32'd0);
`endif
        end
    endtask

    // One cycle on which the output must change to lvl (with the matching strobe).
    task automatic commit(input string tag, input logic lvl);
        step();
        check(tag, {31'd0, button_valid}, {31'd0, lvl});
`ifdef BUTTON_DEBOUNCE_EDGE_EN
        check({tag, "_press"}, {31'd0, button_press}, {31'd0, lvl});
        check({tag, "_release"}, {31'd0, button_release}, {31'd0, ~lvl});
`endif
    endtask

    initial begin
        int seg [6] = '{1, 5, 8, 10, 19, 6};

        // Reset with the button released.
        rst = 1'b1;
        button_in = 1'b0;
        step(); step(); step();
        check("rst_valid", {31'd0, button_valid}, 32'd0);
        check("rst_cnt", 32'(dut.cnt_r), 32'd0);
        rst = 1'b0;
        run("idle", 1'b0, 5, 1'b0);
        check("idle_cnt", 32'(dut.cnt_r), 32'd0);

        // Bouncy press: every segment is shorter than N, then a clean hold.
        for (int i = 0; i < 6; i++) begin
            run("press_bounce", (i % 2 == 0) ? 1'b1 : 1'b0, seg[i], 1'b0);
        end
        run("press_wait", 1'b1, N + 1, 1'b0);
        commit("press_edge", 1'b1);
        run("press_hold", 1'b1, 40, 1'b1);

        // Bouncy release, mirror image.
        for (int i = 0; i < 6; i++) begin
            run("release_bounce", (i % 2 == 0) ? 1'b0 : 1'b1, seg[i], 1'b1);
        end
        run("release_wait", 1'b0, N + 1, 1'b1);
        commit("release_edge", 1'b0);
        run("release_hold", 1'b0, 40, 1'b0);

        // N-1 cycle pulse is rejected.
        run("pulse19_hi", 1'b1, N - 1, 1'b0);
        run("pulse19_lo", 1'b0, 25, 1'b0);

        // N cycle pulse is accepted, and its end is accepted N cycles later.
        run("pulse20_hi", 1'b1, N, 1'b0);
        run("pulse20_lo", 1'b0, 1, 1'b0);
        commit("pulse20_rise", 1'b1);
        run("pulse20_high", 1'b0, N - 1, 1'b1);
        commit("pulse20_fall", 1'b0);
        run("pulse20_after", 1'b0, 5, 1'b0);

        // Reset mid-count discards progress.
        run("midrst_pre", 1'b1, 15, 1'b0);
        rst = 1'b1;
        step();
        check("midrst_valid", {31'd0, button_valid}, 32'd0);
        check("midrst_cnt", 32'(dut.cnt_r), 32'd0);
`ifdef BUTTON_DEBOUNCE_EDGE_EN
        check("midrst_press", {31'd0, button_press}, 32'd0);
        check("midrst_release", {31'd0, button_release}, 32'd0);
`endif
        rst = 1'b0;
        run("midrst_wait", 1'b1, N + 1, 1'b0);
        commit("midrst_rise", 1'b1);
        run("midrst_hold", 1'b1, 10, 1'b1);

        // Clean release to finish.
        run("final_wait", 1'b0, N + 1, 1'b1);
        commit("final_fall", 1'b0);
        run("final_hold", 1'b0, 5, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
